// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default clock/baud and the baud divisor helper.
// Used by both the receiver and the transmitter so frame timing always matches.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} uart_state_t;

  localparam int DEFAULT_CLK_FREQUENCY = 100_000_000;
  localparam int DEFAULT_BAUD_RATE     = 19_200;

  function automatic int baud_clocks(input int clk_frequency, input int baud_rate);
    return clk_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/baud_timer.sv
// Free-running bit-period counter: counts 0..limit, asserts done on limit and wraps.
// clear forces the count back to 0 on the next edge; no backpressure.
module baud_timer #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);

  logic [WIDTH-1:0] count;

  assign done = (count == limit);

  always_ff @(posedge clk) begin
    if (rst || clear || done) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (odd parity bit added when UART_RX_PARITY_EN is defined); byte + error on a 1-cycle strobe.
// Strobe lands on the edge of the mid-stop-bit sample; no consumer handshake, a new byte overwrites dout.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = DEFAULT_CLK_FREQUENCY,
  parameter int BAUD_RATE     = DEFAULT_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] dout,
  output logic       data_strobe,
  output logic       busy,
  output logic       rx_error
);

  localparam int BAUD_CLOCKS = baud_clocks(CLK_FREQUENCY, BAUD_RATE);
  localparam int HALF_BAUD   = BAUD_CLOCKS / 2;
  localparam int TIMER_W     = $clog2(BAUD_CLOCKS + 1);

  uart_state_t        state, state_next;
  logic               rx_meta, rxs;
  logic [7:0]         shift_reg;
  logic [2:0]         bit_cnt;
  logic               err_pend;
  logic               tick;
  logic               timer_clear;
  logic [TIMER_W-1:0] timer_limit;
  logic               frame_go;
  logic               shift_en;
  logic               stop_smp;
`ifdef UART_RX_PARITY_EN
  logic               par_smp;
`endif

  // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  assign timer_limit = (state == START) ? TIMER_W'(HALF_BAUD - 1) : TIMER_W'(BAUD_CLOCKS - 1);

  baud_timer #(.WIDTH(TIMER_W)) u_baud_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .limit (timer_limit),
    .done  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    frame_go   = 1'b0;
    shift_en   = 1'b0;
    stop_smp   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxs) state_next = START;
      end
      START: begin
        if (tick) begin
          if (!rxs) begin
            state_next = DATA;
            frame_go   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PAR;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PAR: begin
        if (tick) begin
          par_smp    = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          stop_smp   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Holding the timer at zero in IDLE means it starts from 0 on every state entry.
    timer_clear = (state == IDLE) || (state_next != state);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg   <= 8'h00;
      bit_cnt     <= 3'd0;
      err_pend    <= 1'b0;
      dout        <= 8'h00;
      data_strobe <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      data_strobe <= stop_smp;
      if (frame_go) begin
        bit_cnt  <= 3'd0;
        err_pend <= 1'b0;
      end
      if (shift_en) begin
        shift_reg <= {rxs, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if (par_smp && (rxs != ~(^shift_reg))) begin
        err_pend <= 1'b1;
      end
`endif
      if (stop_smp) begin
        dout     <= shift_reg;
        rx_error <= err_pend | ~rxs;
        err_pend <= err_pend | ~rxs;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the UART link. It accepts 8N1 frames at a fixed baud rate, with an optional odd parity bit, and delivers each received byte with a one-cycle strobe. It sits between the board-level RX pin and on-chip byte consumers. It is the receiving end of the team's UART transmitter and uses the same frame format, parity convention and baud parameters.

## Interface
- CLK_FREQUENCY, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 19_200: line bit rate.
- Derived constants: BAUD_CLOCKS = CLK_FREQUENCY/BAUD_RATE (integer division; 5208 at defaults). HALF_BAUD = BAUD_CLOCKS/2 (2604).
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- rx_in  input  1  asynchronous serial line; idles high.
- dout  output  8  last received byte, LSB first on the wire; stable until the next strobe.
- data_strobe  output  1  one-cycle pulse when dout holds a new byte.
- busy  output  1  high while a frame is being received.
- rx_error  output  1  framing or parity error on the last frame; valid with data_strobe.

## Operation
- rx_in passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized value rxs.
- FSM states:
  - IDLE: busy=0. Stays here while rxs=1. When rxs=0, clears the timer and goes to START.
  - START: waits HALF_BAUD cycles.
    - If rxs=0 at the sample, clears the timer and the bit counter, then goes to DATA.
    - If rxs=1 at the sample, the edge was a glitch: returns to IDLE with no strobe and no error.
  - DATA: samples rxs every BAUD_CLOCKS cycles, so each sample falls at mid-bit. The sampled bit shifts into a shift register from the MSB end, so the first-received bit ends up as LSB. The bit counter runs 0..7. After the 8th sample, goes to PAR if parity is compiled in, otherwise to STOP.
  - PAR: one sample after BAUD_CLOCKS. Expected value is odd parity: the XOR of the data bits, inverted. A mismatch sets a pending error flag. Then goes to STOP.
  - STOP: one sample after BAUD_CLOCKS. rxs=0 sets the pending error flag (framing error). On the sample:
    - dout is loaded from the shift register.
    - rx_error is loaded from the pending flag.
    - data_strobe pulses.
    - FSM returns to IDLE immediately; no wait for a full stop bit.
- busy = 1 in START, DATA, PAR and STOP.
- A frame with an error still delivers its byte: dout is updated and data_strobe pulses.
- rx_error holds its value until the next data_strobe.

## Timing
- Reset values:
  - dout = 0x00, data_strobe = 0, busy = 0, rx_error = 0.
  - FSM = IDLE, timer = 0, bit counter = 0, pending error flag = 0.
- Reset mid-frame: the frame is aborted, no strobe is issued, and the block returns to the reset values.
- Timer: counts 0..N-1 and fires on count N-1, where N = HALF_BAUD in START and BAUD_CLOCKS elsewhere. It clears whenever the state changes.
- Latency: data_strobe is asserted on the clock edge after the stop-bit sample. At defaults, about 9.5 bit times (parity compiled out) or 10.5 bit times (parity compiled in) after rxs first goes low.
- Back-to-back frames: a start edge arriving one bit time after the stop sample, or any later time, is accepted.
- A low rxs in IDLE the cycle after the strobe starts a new frame in the next cycle.
- No consumer handshake. Overrun is not flagged; a new strobe overwrites dout.

## Configuration
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The frame carries one odd parity bit after the data bits.
  - The PAR state and the parity check are present.
  - rx_error flags parity or framing errors.
- Undefined:
  - PAR state is absent; the frame is 8N1.
  - rx_error flags framing errors only.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PAR, STOP);
  - default CLK_FREQUENCY and BAUD_RATE;
  - a function computing BAUD_CLOCKS, shared with the transmitter.
- One sub-module, baud_timer: a parameterized counter with clear and done, also reusable by the transmitter.
- The synchronizer, FSM, shift register and bit counter are all in uart_rx.

## Test plan
- Reset, then line idle high for 1 ms -> busy=0, data_strobe never asserts, dout=0x00, rx_error=0.
- Clean frame 0x55, parity bit 1 when compiled in, stop bit 1 -> exactly one strobe, dout=0x55, rx_error=0; strobe about 9.5 or 10.5 bit times after the start edge.
- Frame 0xA3 with stop bit driven 0 -> strobe, dout=0xA3, rx_error=1. Then a clean frame 0x07 -> rx_error=0.
- With UART_RX_PARITY_EN, frame 0x07 with parity bit 1 (wrong) -> dout=0x07, rx_error=1.
- 1000-cycle low glitch on idle line -> FSM returns to IDLE, no strobe. Then back-to-back frames 0x00 and 0xFF -> two strobes with the correct values.
- Assert rst during DATA of 0x3C -> no strobe and reset values restored. The next clean frame 0x3C is received correctly.
